// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for a 5-stage RV32I core: load-use stall detection,
// EX operand forwarding selects, branch flush sequencing and stall/flush counters.
module hazard_ctrl #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int FLUSH_CYCLES   = 2,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      id_valid,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
  input  logic                      id_uses_rs1,
  input  logic                      id_uses_rs2,
  input  logic [REG_ADDR_WIDTH-1:0] id_rd,
  input  logic                      id_RegWrite,
  input  logic                      id_MemRead,
  input  logic                      branch_taken,
  output logic                      stall,
  output logic                      bubble_ex,
  output logic                      flush,
  output logic [1:0]                fwd_a,
  output logic [1:0]                fwd_b,
  output logic [CNT_WIDTH-1:0]      stall_cnt,
  output logic [CNT_WIDTH-1:0]      flush_cnt
);

  // state | meaning
  // RUN   | normal issue; load-use stalls allowed, taken branch starts a flush
  // FLUSH | squash IF/ID and ID/EX for FLUSH_CYCLES cycles, branches ignored
  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

  localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  state_t              state, state_nx;
  logic [FW-1:0]       fcnt, fcnt_nx;

  // The WB entry is implicit: a MEM hit found at issue is the WB producer
  // once the consumer reaches EX, so only EX and MEM fields are stored.
  logic                      ex_v, ex_rw, ex_mr;
  logic [REG_ADDR_WIDTH-1:0] ex_rd;
  logic                      mem_v, mem_rw;
  logic [REG_ADDR_WIDTH-1:0] mem_rd;

  logic       ex_ld, load_use, issue;
  logic       a_ex, a_mem, b_ex, b_mem;
  logic [1:0] fwd_a_nx, fwd_b_nx;

  assign ex_ld    = ex_v & ex_mr & (ex_rd != '0);
  assign load_use = id_valid & ex_ld &
                    ((id_uses_rs1 & (id_rs1 == ex_rd)) | (id_uses_rs2 & (id_rs2 == ex_rd)));

  assign a_ex  = id_uses_rs1 & ex_v  & ex_rw  & (ex_rd  != '0) & (ex_rd  == id_rs1);
  assign a_mem = id_uses_rs1 & mem_v & mem_rw & (mem_rd != '0) & (mem_rd == id_rs1);
  assign b_ex  = id_uses_rs2 & ex_v  & ex_rw  & (ex_rd  != '0) & (ex_rd  == id_rs2);
  assign b_mem = id_uses_rs2 & mem_v & mem_rw & (mem_rd != '0) & (mem_rd == id_rs2);

  assign fwd_a_nx = a_ex ? 2'b10 : (a_mem ? 2'b01 : 2'b00);
  assign fwd_b_nx = b_ex ? 2'b10 : (b_mem ? 2'b01 : 2'b00);

  always_comb begin
    state_nx = state;
    fcnt_nx  = fcnt;
    stall    = 1'b0;
    flush    = 1'b0;
    case (state)
      RUN: begin
        stall = load_use;
        if (branch_taken) begin
          state_nx = FLUSH;
          fcnt_nx  = FW'(FLUSH_CYCLES - 1);
        end
      end
      FLUSH: begin
        flush = 1'b1;
        if (fcnt == '0) state_nx = RUN;
        else            fcnt_nx  = fcnt - FW'(1);
      end
      default: state_nx = RUN;
    endcase
  end

  assign bubble_ex = stall | flush;
  assign issue     = id_valid & ~stall & ~flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RUN;
      fcnt  <= '0;
    end else begin
      state <= state_nx;
      fcnt  <= fcnt_nx;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_v   <= 1'b0;
      ex_rw  <= 1'b0;
      ex_mr  <= 1'b0;
      ex_rd  <= '0;
      mem_v  <= 1'b0;
      mem_rw <= 1'b0;
      mem_rd <= '0;
      fwd_a  <= 2'b00;
      fwd_b  <= 2'b00;
    end else begin
      mem_v  <= ex_v;
      mem_rw <= ex_rw;
      mem_rd <= ex_rd;
      ex_v   <= issue;
      if (issue) begin
        ex_rw <= id_RegWrite;
        ex_mr <= id_MemRead;
        ex_rd <= id_rd;
        fwd_a <= fwd_a_nx;
        fwd_b <= fwd_b_nx;
      end else begin
        fwd_a <= 2'b00;
        fwd_b <= 2'b00;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_WIDTH'(1);
      if (flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage RV32I pipeline. Sits beside the ID stage.
- Tracks the destination registers of in-flight instructions in EX, MEM and WB with a small internal scoreboard.
- Detects load-use hazards and stalls IF/ID. Issues forwarding selects to EX. Sequences branch-taken flushes through a small FSM.
- Keeps saturating stall and flush performance counters.

Parameters:
REG_ADDR_WIDTH, 5, register address width
FLUSH_CYCLES, 2, cycles flush held after a taken branch (must be >= 1)
CNT_WIDTH, 16, width of performance counters

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
id_valid  input  1  ID holds a real instruction
id_rs1  input  REG_ADDR_WIDTH  ID source register 1
id_rs2  input  REG_ADDR_WIDTH  ID source register 2
id_uses_rs1  input  1  ID instruction reads rs1
id_uses_rs2  input  1  ID instruction reads rs2
id_rd  input  REG_ADDR_WIDTH  ID destination register
id_RegWrite  input  1  ID instruction writes the register file
id_MemRead  input  1  ID instruction is a load
branch_taken  input  1  EX resolved a taken branch/jump this cycle
stall  output  1  hold PC and IF/ID register
bubble_ex  output  1  insert NOP into ID/EX register
flush  output  1  squash IF/ID and ID/EX contents
fwd_a  output  2  EX operand A select: 00 regfile, 10 MEM-stage result, 01 WB-stage result
fwd_b  output  2  EX operand B select, same encoding
stall_cnt  output  CNT_WIDTH  load-use stall cycles, saturating
flush_cnt  output  CNT_WIDTH  flush cycles, saturating

Behaviour:
- Reset (reset=0, async): all scoreboard valids=0, FSM=RUN, fwd_a=fwd_b=00, counters=0. Outputs stall=bubble_ex=flush=0.
- Scoreboard has 3 entries: ex, mem, wb. Each entry holds {valid, rd, RegWrite, MemRead}.
  - Every cycle: wb<=mem, mem<=ex.
  - ex<=ID fields when issuing. An issue requires id_valid=1, stall=0 and flush=0.
  - Otherwise ex.valid<=0, which is a bubble.
- Load-use stall is combinational. stall=1 when all of:
  - state=RUN
  - id_valid
  - ex.valid & ex.MemRead & ex.rd!=0
  - (id_uses_rs1 & id_rs1==ex.rd) | (id_uses_rs2 & id_rs2==ex.rd)
- bubble_ex = stall | flush.
- Forwarding is computed at issue and registered into fwd_a/fwd_b, so it is valid while that instruction is in EX.
  - For rs1: if ex.valid & ex.RegWrite & ex.rd!=0 & ex.rd==id_rs1 & id_uses_rs1, then 10. That producer will be in MEM next cycle.
  - Else if mem.valid & mem.RegWrite & mem.rd!=0 & mem.rd==id_rs1 & id_uses_rs1, then 01.
  - Else 00. rs2 uses the same rules.
  - The MEM match always has priority over the WB match.
  - On a bubble, fwd_a=fwd_b=00.
- Register x0 never matches.
- FSM states are RUN and FLUSH. Internal counter fcnt.
  - RUN & branch_taken: go to FLUSH next cycle with fcnt=FLUSH_CYCLES-1.
  - flush=1 in every cycle the FSM is in FLUSH.
  - FLUSH & fcnt==0: go to RUN. Otherwise fcnt decrements.
  - branch_taken while in FLUSH is ignored, because EX holds a bubble.
- Simultaneous branch_taken and load-use in RUN: the stall is still asserted that cycle, and FLUSH follows next cycle. The flush discards the stalled instruction.
- In FLUSH, stall is forced to 0.
- stall_cnt increments on every cycle with stall=1. flush_cnt increments on every cycle with flush=1. Both saturate at all-ones with no wrap.
- Reset asserted mid-flush or mid-stall: immediate return to the reset state. No pending flush survives reset.
- Latency: stall and bubble_ex are combinational, same cycle. fwd_* and flush are registered, taking effect one cycle after the cause.

Test Plan:
- Load-use: lw x5 issued, then ID add x6,x5,x1 -> stall=1 for exactly 1 cycle. Next cycle add issues with fwd_a=01 and stall_cnt=1.
- EX->EX forwarding: addi x3 issued, then ID sub x4,x1,x3 (uses rs2) -> no stall. Next cycle fwd_b=10, fwd_a=00.
- Priority and x0: x7 written by two consecutive instructions, third reads x7 -> fwd=10 (not 01). A lw x0 followed by use of x0 -> no stall, fwd=00.
- Branch flush: branch_taken pulse in RUN -> flush=1 for exactly 2 cycles starting next cycle. A second branch_taken during FLUSH is ignored. flush_cnt=2.
- Simultaneous: load-use plus branch_taken in the same cycle -> stall=1 that cycle, then flush=1 for 2 cycles. No issue occurs until back in RUN.
- Async reset: reset=0 pulsed mid-FLUSH between clock edges -> flush, counters and fwd go to 0 immediately. After release, state is RUN and the next load-use behaves normally.
